// File: rtl/led_ctrl_pkg.sv
// Shared types and constants for the LED status arbiter.
// LED_ARB_ROUND_ROBIN_EN selects round-robin arbitration in led_status_arbiter.
package led_ctrl_pkg;

    typedef enum logic {
        StIdle,
        StOwn
    } arb_state_e;

    typedef logic [2:0] rgb_t;

    localparam int unsigned LED_W = 4;

endpackage

// File: rtl/led_tick_gen.sv
// Free-running divider producing a one-cycle tick every CLK_FREQ/TICK_FREQ cycles.
// The tick is asserted combinationally during the wrap cycle of the counter.
module led_tick_gen #(
    parameter int unsigned CLK_FREQ  = 12000000,
    parameter int unsigned TICK_FREQ = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o
);

    localparam int unsigned DIV   = CLK_FREQ / TICK_FREQ;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == CNT_MAX);
    assign tick_o = w_wrap;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_status_arbiter.sv
// Arbitrates NUM_REQ status requesters onto one RGB LED plus a 4-bit LED bank.
// Define LED_ARB_ROUND_ROBIN_EN for round-robin; default build is fixed priority.
module led_status_arbiter
    import led_ctrl_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 12000000,
    parameter int unsigned TICK_FREQ  = 4,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned HOLD_TICKS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [3*NUM_REQ-1:0]   req_rgb_i,
    input  logic [4*NUM_REQ-1:0]   req_led_i,
    input  logic [NUM_REQ-1:0]     req_blink_i,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic                   led0_r_o,
    output logic                   led0_g_o,
    output logic                   led0_b_o,
    output logic [LED_W-1:0]       led_o,
    output logic                   busy_o
);

    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned HOLD_W = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_TICKS);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_REQ - 1);

    arb_state_e          r_state;
    logic [IDX_W-1:0]    r_owner;
    logic [NUM_REQ-1:0]  r_grant;
    logic [HOLD_W-1:0]   r_hold;
    logic                r_phase;
    rgb_t                r_rgb;
    logic [LED_W-1:0]    r_led;
    logic                r_busy;

    logic                w_tick;
    logic                w_phase_nxt;
    logic                w_owner_req;
    logic                w_hold_done;
    logic                w_rearb;
    logic                w_pick_valid;
    logic                w_nxt_valid;
    logic                w_nxt_blank;
    logic [NUM_REQ-1:0]  w_arb_req;
    logic [IDX_W-1:0]    w_start;
    logic [IDX_W-1:0]    w_pick;
    logic [IDX_W-1:0]    w_nxt_idx;
    rgb_t                w_rgb_arr [NUM_REQ];
    logic [LED_W-1:0]    w_led_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_rgb_arr[g] = req_rgb_i[3*g +: 3];
        assign w_led_arr[g] = req_led_i[4*g +: 4];
    end

    led_tick_gen #(
        .CLK_FREQ  (CLK_FREQ),
        .TICK_FREQ (TICK_FREQ)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .tick_o (w_tick)
    );

`ifdef LED_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] r_rr_ptr;
    assign w_start = r_rr_ptr;
`else
    assign w_start = '0;
`endif

    // Circular search from start; returns {found, index}.
    function automatic logic [IDX_W:0] pick_req(input logic [NUM_REQ-1:0] req,
                                                input logic [IDX_W-1:0]   start);
        logic             found;
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] win;
        found = 1'b0;
        win   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = IDX_W'((32'(start) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        return {found, win};
    endfunction

    always_comb begin
        w_phase_nxt = r_phase ^ w_tick;
        w_owner_req = |(req_i & r_grant);
        w_hold_done = (r_hold == HOLD_MAX);
        // An owner dropping its request always wins over hold expiry.
        if (r_state == StIdle || !w_owner_req) begin
            w_rearb   = 1'b1;
            w_arb_req = req_i;
        end else begin
            w_arb_req = req_i & ~r_grant;
            w_rearb   = w_hold_done && (|w_arb_req);
        end
        {w_pick_valid, w_pick} = pick_req(w_arb_req, w_start);
        w_nxt_valid = w_rearb ? w_pick_valid : 1'b1;
        w_nxt_idx   = w_rearb ? w_pick : r_owner;
        w_nxt_blank = req_blink_i[w_nxt_idx] && !w_phase_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_owner <= '0;
            r_grant <= '0;
            r_hold  <= '0;
            r_phase <= 1'b0;
            r_rgb   <= '0;
            r_led   <= '0;
            r_busy  <= 1'b0;
`ifdef LED_ARB_ROUND_ROBIN_EN
            r_rr_ptr <= '0;
`endif
        end else begin
            r_phase <= w_phase_nxt;
            if (w_nxt_valid) begin
                r_state <= StOwn;
                r_owner <= w_nxt_idx;
                r_grant <= NUM_REQ'(1) << w_nxt_idx;
                r_busy  <= 1'b1;
                r_rgb   <= w_nxt_blank ? '0 : w_rgb_arr[w_nxt_idx];
                r_led   <= w_nxt_blank ? '0 : w_led_arr[w_nxt_idx];
                if (w_rearb) begin
                    r_hold <= '0;
                end else if (w_tick && !w_hold_done) begin
                    r_hold <= r_hold + 1'b1;
                end
`ifdef LED_ARB_ROUND_ROBIN_EN
                if (w_rearb) begin
                    r_rr_ptr <= (w_nxt_idx == IDX_LAST) ? '0 : w_nxt_idx + 1'b1;
                end
`endif
            end else begin
                r_state <= StIdle;
                r_grant <= '0;
                r_hold  <= '0;
                r_rgb   <= '0;
                r_led   <= '0;
                r_busy  <= 1'b0;
            end
        end
    end

    assign grant_o  = r_grant;
    assign led0_r_o = r_rgb[2];
    assign led0_g_o = r_rgb[1];
    assign led0_b_o = r_rgb[0];
    assign led_o    = r_led;
    assign busy_o   = r_busy;

endmodule

// File: tb/tb_led_status_arbiter.sv
// Directed scoreboard bench for led_status_arbiter (NUM_REQ=4, tick every 10 cycles, hold 2).
// Expectations adapt to LED_ARB_ROUND_ROBIN_EN when the bench is built with it.
module tb_led_status_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_i = '0;
    logic [11:0] req_rgb_i = '0;
    logic [15:0] req_led_i = '0;
    logic [3:0]  req_blink_i = '0;
    logic [3:0]  grant_o;
    logic        led0_r_o;
    logic        led0_g_o;
    logic        led0_b_o;
    logic [3:0]  led_o;
    logic        busy_o;

    always #5 clk = ~clk;

    led_status_arbiter #(
        .CLK_FREQ   (1000),
        .TICK_FREQ  (100),
        .NUM_REQ    (4),
        .HOLD_TICKS (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .req_rgb_i   (req_rgb_i),
        .req_led_i   (req_led_i),
        .req_blink_i (req_blink_i),
        .grant_o     (grant_o),
        .led0_r_o    (led0_r_o),
        .led0_g_o    (led0_g_o),
        .led0_b_o    (led0_b_o),
        .led_o       (led_o),
        .busy_o      (busy_o)
    );

    logic [2:0]  rgb_tab   [4];
    logic [3:0]  led_tab   [4];
    logic        blink_tab [4];
    logic [11:0] exp_q [$];
    string       tag_q [$];
    int          n;
    int          tests;
    int          fails;

    // Expected {grant, r, g, b, led, busy} for a given owner and blink phase after the edge.
    function automatic logic [11:0] expv(input logic [3:0] g, input logic ph);
        logic [11:0] v;
        v = '0;
        for (int k = 0; k < 4; k++) begin
            if (g[k]) begin
                if (blink_tab[k] && !ph) v = {g, 3'b000, 4'h0, 1'b1};
                else                     v = {g, rgb_tab[k], led_tab[k], 1'b1};
            end
        end
        return v;
    endfunction

    task automatic step(input string tag, input logic [3:0] g);
        int          n_nxt;
        logic [11:0] e;
        logic [11:0] obs;
        string       t;
        for (int k = 0; k < 4; k++) begin
            req_rgb_i[3*k +: 3] = rgb_tab[k];
            req_led_i[4*k +: 4] = led_tab[k];
            req_blink_i[k]      = blink_tab[k];
        end
        n_nxt = rst ? 0 : n + 1;
        e = rst ? 12'h000 : expv(g, ((n_nxt / 10) % 2) == 1);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        n = n_nxt;
        #1;
        obs = {grant_o, led0_r_o, led0_g_o, led0_b_o, led_o, busy_o};
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        tests++;
        assert (obs === e) else begin
            fails++;
            $error("FAIL %s (edge %0d): observed grant/rgb/led/busy=%h expected %h", t, n, obs, e);
        end
        tests++;
        assert ($onehot0(grant_o)) else begin
            fails++;
            $error("FAIL %s_onehot (edge %0d): observed grant=%b expected one-hot or zero",
                   t, n, grant_o);
        end
    endtask

    initial begin
        logic [3:0] g;
        int         s;
        n = 0;
        tests = 0;
        fails = 0;
        rgb_tab   = '{3'b001, 3'b100, 3'b010, 3'b111};
        led_tab   = '{4'h1, 4'h5, 4'hA, 4'hF};
        blink_tab = '{1'b0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        step("reset_a", 4'b0000);
        step("reset_b", 4'b0000);
        rst = 1'b0;
        step("idle", 4'b0000);

        req_i = 4'b0010;
        step("grant1", 4'b0010);
        req_i = 4'b0011;
        for (int i = 3; i <= 20; i++) step("hold_owner1", 4'b0010);
        step("expiry_switch", 4'b0001);
        step("keep0", 4'b0001);

        req_i = 4'b0100;
        step("drop_to2", 4'b0100);

        blink_tab[2] = 1'b1;
        led_tab[2]   = 4'hF;
        for (int i = 24; i <= 45; i++) step("blink", 4'b0100);

        blink_tab[2] = 1'b0;
        rgb_tab[2]   = 3'b011;
        step("follow_rgb", 4'b0100);
        led_tab[2] = 4'h3;
        step("follow_led", 4'b0100);

        rst = 1'b1;
        step("rst_while_own", 4'b0000);
        rst = 1'b0;
        step("regrant", 4'b0100);
        for (int i = 2; i <= 20; i++) step("hold_owner2", 4'b0100);

        req_i = 4'b0001;
        step("drop_at_expiry", 4'b0001);
        req_i = 4'b0000;
        step("drop_to_idle", 4'b0000);

        rst = 1'b1;
        step("reset_c", 4'b0000);
        rst = 1'b0;
        req_i = 4'b1111;
        for (int i = 1; i <= 85; i++) begin
            s = (i - 1) / 20;
`ifdef LED_ARB_ROUND_ROBIN_EN
            g = 4'b0001 << (s % 4);
`else
            g = ((s % 2) == 0) ? 4'b0001 : 4'b0010;
`endif
            step("rotate", g);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
